// File: rtl/iob_eth_tx_framer_pkg.sv
// Shared constants and state type for the MII TX frame builder.
// Defaults match the Ethernet preamble length and the min/max frame sizes without FCS.
package iob_eth_tx_framer_pkg;

  localparam int DEF_PREAMBLE_LEN = 7;
  localparam int DEF_MIN_FRAME    = 60;
  localparam int DEF_MAX_FRAME    = 1514;
  localparam int ADDR_W           = 11;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PAD_BYTE      = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_DATA    = 3'd2,
    ST_PAD     = 3'd3,
    ST_DISCARD = 3'd4,
    ST_SEND    = 3'd5,
    ST_WAIT    = 3'd6
  } framer_state_t;

  function automatic logic [7:0] pre_byte(input logic is_sfd);
    return is_sfd ? SFD_BYTE : PREAMBLE_BYTE;
  endfunction

endpackage

// File: rtl/iob_eth_tx_framer.sv
// Builds preamble + SFD + payload (zero-padded to minimum length) in the TX byte
// buffer, then hands the frame to the MII transmitter with a send request.
module iob_eth_tx_framer
  import iob_eth_tx_framer_pkg::*;
#(
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter int MIN_FRAME    = DEF_MIN_FRAME,
  parameter int MAX_FRAME    = DEF_MAX_FRAME
) (
  input  logic              tx_clk_i,
  input  logic              tx_arst_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_addr_o,
  output logic [7:0]        buf_wdata_o,
  output logic [ADDR_W-1:0] nbytes_o,
  output logic              send_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              drop_o
);

  localparam logic [ADDR_W-1:0] L_SFD_ADDR = ADDR_W'(PREAMBLE_LEN);
  localparam logic [ADDR_W-1:0] L_HDR      = ADDR_W'(PREAMBLE_LEN + 1);
  localparam logic [ADDR_W-1:0] L_MIN      = ADDR_W'(MIN_FRAME);
  localparam logic [ADDR_W-1:0] L_MAX      = ADDR_W'(MAX_FRAME);

  framer_state_t     r_state;
  framer_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_len;
  logic              w_we;
  logic [7:0]        w_wdata;
  logic              w_drop;

  // Payload bytes already written; the header occupies the first addresses.
  assign w_len     = r_addr - L_HDR;
  assign s_ready_o = (r_state == ST_DATA) || (r_state == ST_DISCARD);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_we        = 1'b0;
    w_wdata     = PAD_BYTE;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_valid_i && tx_ready_i) begin
          w_state_nxt = ST_PRE;
          w_addr_nxt  = '0;
        end
      end
      ST_PRE: begin
        w_we       = 1'b1;
        w_wdata    = pre_byte(r_addr == L_SFD_ADDR);
        w_addr_nxt = r_addr + 1'b1;
        if (r_addr == L_SFD_ADDR) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (s_valid_i) begin
          if (w_len == L_MAX) begin
            // Byte MAX_FRAME+1: frame is oversize, stop writing.
            if (s_last_i) begin
              w_drop      = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_DISCARD;
            end
          end else begin
            w_we       = 1'b1;
            w_wdata    = s_data_i;
            w_addr_nxt = r_addr + 1'b1;
            if (s_last_i) w_state_nxt = ((w_len + 1'b1) < L_MIN) ? ST_PAD : ST_SEND;
          end
        end
      end
      ST_PAD: begin
        w_we       = 1'b1;
        w_wdata    = PAD_BYTE;
        w_addr_nxt = r_addr + 1'b1;
        if ((w_len + 1'b1) == L_MIN) w_state_nxt = ST_SEND;
      end
      ST_DISCARD: begin
        if (s_valid_i && s_last_i) begin
          w_drop      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!tx_ready_i) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk_i or posedge tx_arst_i) begin
    if (tx_arst_i) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      buf_we_o    <= 1'b0;
      buf_addr_o  <= '0;
      buf_wdata_o <= '0;
      nbytes_o    <= '0;
      send_o      <= 1'b0;
      busy_o      <= 1'b0;
      drop_o      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      buf_we_o    <= w_we;
      buf_addr_o  <= r_addr;
      buf_wdata_o <= w_wdata;
      drop_o      <= w_drop;
      send_o      <= (w_state_nxt == ST_SEND);
      busy_o      <= (w_state_nxt != ST_IDLE);
      // Latch the frame size together with the first cycle of send.
      if ((w_state_nxt == ST_SEND) && (r_state != ST_SEND)) nbytes_o <= w_addr_nxt;
    end
  end

endmodule
